// File: rtl/clk_rst_seq_if.sv
// Reset-sequencer signal bundle: wizard lock status and software restart in,
// wizard/system resets and status out.
interface clk_rst_seq_if;
  logic       locked;
  logic       sw_rst_req;
  logic       wiz_resetn;
  logic       sys_rst_n;
  logic       seq_busy;
  logic       lock_fail;
  logic [3:0] retry_cnt;

  modport master (
    input  locked,
    input  sw_rst_req,
    output wiz_resetn,
    output sys_rst_n,
    output seq_busy,
    output lock_fail,
    output retry_cnt
  );

  modport slave (
    output locked,
    output sw_rst_req,
    input  wiz_resetn,
    input  sys_rst_n,
    input  seq_busy,
    input  lock_fail,
    input  retry_cnt
  );
endinterface

// File: rtl/clk_rst_seq.sv
// Clock-wizard reset sequencer: holds the wizard in reset, waits for a stable
// lock with bounded retries, then releases the downstream system reset.
module clk_rst_seq #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic          clk_in1,
  input  logic          resetn,
  clk_rst_seq_if.master bus
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        locked_meta_q, locked_s_q;
  logic        wiz_q, sys_q, busy_q, fail_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    retry_d = retry_q;
    case (state_q)
      HOLD:      if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock seen on the timeout cycle still wins over the retry
        if (locked_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = HOLD;
          end else begin
            state_d = FAIL;
          end
        end
      end
      STABLE: begin
        if (!locked_s_q)                state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = HOLD;
          if (retry_q != '1) retry_d = retry_q + 4'd1;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = HOLD;
    endcase
    if (state_d != state_q || state_q == RUN || state_q == FAIL) cnt_d = '0;
    if (bus.sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the state register.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= HOLD;
      cnt_q         <= '0;
      retry_q       <= '0;
      wiz_q         <= 1'b0;
      sys_q         <= 1'b0;
      busy_q        <= 1'b1;
      fail_q        <= 1'b0;
    end else begin
      locked_meta_q <= bus.locked;
      locked_s_q    <= locked_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      wiz_q         <= !(state_d == HOLD || state_d == FAIL);
      sys_q         <= (state_d == RUN);
      busy_q        <= (state_d == HOLD || state_d == WAIT_LOCK || state_d == STABLE);
      fail_q        <= (state_d == FAIL);
    end
  end

  assign bus.wiz_resetn = wiz_q;
  assign bus.sys_rst_n  = sys_q;
  assign bus.seq_busy   = busy_q;
  assign bus.lock_fail  = fail_q;
  assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with small parameters; expected values are
// queued when a step is driven and popped as each observation is taken.
module tb_clk_rst_seq;

  logic clk_in1 = 1'b0;
  logic resetn;

  clk_rst_seq_if bus ();

  clk_rst_seq #(
    .HOLD_CYCLES  (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk_in1(clk_in1),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in1);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.sys_rst_n;
      1:       return bus.wiz_resetn;
      2:       return bus.seq_busy;
      default: return bus.lock_fail;
    endcase
  endfunction

  // Counts edges until the selected output reads v; an expired budget yields
  // n = budget, which the following comparison rejects.
  task automatic wait_for(input int sel, input logic v, input int budget, output int n);
    n = 0;
    while (sig(sel) !== v && n < budget) begin
      @(posedge clk_in1);
      #1;
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    push({pfx, "_wiz"}, 0);   pop_chk(32'(bus.wiz_resetn));
    push({pfx, "_sys"}, 0);   pop_chk(32'(bus.sys_rst_n));
    push({pfx, "_busy"}, 1);  pop_chk(32'(bus.seq_busy));
    push({pfx, "_fail"}, 0);  pop_chk(32'(bus.lock_fail));
    push({pfx, "_retry"}, 0); pop_chk(32'(bus.retry_cnt));
  endtask

  initial begin
    int n1, n2;
    logic sys_ever;

    resetn         = 1'b0;
    bus.locked     = 1'b1;
    bus.sw_rst_req = 1'b0;

    // Reset values while held in reset
    step(3);
    chk_reset_vals("rst");

    // Locked tied high: wizard released after 4, system after 13 edges
    resetn = 1'b1;
    wait_for(1, 1'b1, 20, n1);
    push("hi_wiz_rise_edge", 4);  pop_chk(32'(n1));
    wait_for(0, 1'b1, 40, n2);
    push("hi_sys_rise_edge", 13); pop_chk(32'(n1 + n2));
    push("hi_busy_at_rise", 0);   pop_chk(32'(bus.seq_busy));
    push("hi_retry", 0);          pop_chk(32'(bus.retry_cnt));

    // Lock loss in RUN: sys_rst_n falls after 3 edges, one retry consumed
    bus.locked = 1'b0;
    wait_for(0, 1'b0, 10, n1);
    push("loss_sys_fall_edges", 3); pop_chk(32'(n1));
    push("loss_retry", 1);          pop_chk(32'(bus.retry_cnt));
    push("loss_busy", 1);           pop_chk(32'(bus.seq_busy));
    bus.locked = 1'b1;
    wait_for(0, 1'b1, 40, n1);
    push("loss_resequence_edges", 13); pop_chk(32'(n1));
    push("loss_retry_after", 1);       pop_chk(32'(bus.retry_cnt));

    // Software restart, then a one-cycle lock glitch during STABLE
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    push("sw_retry_clr", 0); pop_chk(32'(bus.retry_cnt));
    push("sw_wiz_low", 0);   pop_chk(32'(bus.wiz_resetn));
    step(9);
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    wait_for(0, 1'b1, 60, n1);
    push("glitch_release_edges", 11); pop_chk(32'(n1));
    push("glitch_retry", 0);          pop_chk(32'(bus.retry_cnt));

    // Locked tied low: three 36-cycle attempts, FAIL from edge 108
    bus.locked = 1'b0;
    resetn     = 1'b0;
    step(2);
    resetn   = 1'b1;
    sys_ever = 1'b0;
    push("lo_retry_e35", 0);
    push("lo_retry_e36", 1);
    push("lo_wiz_e39", 0);
    push("lo_wiz_e40", 1);
    push("lo_retry_e72", 2);
    push("lo_fail_e107", 0);
    push("lo_fail_e108", 1);
    push("lo_wiz_e108", 0);
    push("lo_retry_e108", 2);
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk_in1);
      #1;
      if (bus.sys_rst_n !== 1'b0) sys_ever = 1'b1;
      case (e)
        35:  pop_chk(32'(bus.retry_cnt));
        36:  pop_chk(32'(bus.retry_cnt));
        39:  pop_chk(32'(bus.wiz_resetn));
        40:  pop_chk(32'(bus.wiz_resetn));
        72:  pop_chk(32'(bus.retry_cnt));
        107: pop_chk(32'(bus.lock_fail));
        108: begin
          pop_chk(32'(bus.lock_fail));
          pop_chk(32'(bus.wiz_resetn));
          pop_chk(32'(bus.retry_cnt));
        end
        default: ;
      endcase
    end
    push("lo_sys_never_high", 0); pop_chk(32'(sys_ever));

    // Software restart out of FAIL
    bus.locked     = 1'b1;
    bus.sw_rst_req = 1'b1;
    step(1);
    bus.sw_rst_req = 1'b0;
    push("fail_sw_lock_fail", 0); pop_chk(32'(bus.lock_fail));
    push("fail_sw_retry", 0);     pop_chk(32'(bus.retry_cnt));
    push("fail_sw_wiz", 0);       pop_chk(32'(bus.wiz_resetn));
    wait_for(1, 1'b1, 20, n1);
    push("fail_sw_wiz_rise", 4);  pop_chk(32'(n1));
    wait_for(0, 1'b1, 40, n2);
    push("fail_sw_sys_rise", 9);  pop_chk(32'(n2));

    // Asynchronous reset mid-STABLE with a retry already counted
    bus.locked = 1'b0;
    step(3);
    push("stab_sys_low", 0); pop_chk(32'(bus.sys_rst_n));
    bus.locked = 1'b1;
    step(8);
    push("stab_pre_wiz", 1);   pop_chk(32'(bus.wiz_resetn));
    push("stab_pre_busy", 1);  pop_chk(32'(bus.seq_busy));
    push("stab_pre_retry", 1); pop_chk(32'(bus.retry_cnt));
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_vals("async");
    step(2);
    resetn = 1'b1;
    wait_for(0, 1'b1, 40, n1);
    push("async_restart_rise", 13); pop_chk(32'(n1));

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, number of cycles wiz_resetn is held low per attempt (range 1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 1024, cycles allowed for locked to assert after wiz_resetn release (range 1..65535).
REQ-003 Parameter STABLE_CYCLES, default 64, consecutive cycles synchronized locked must stay high before system release (range 1..65535).
REQ-004 Parameter MAX_RETRIES, default 3, lock re-attempts before declaring failure (range 0..15).
REQ-005 clk_in1  input  1  100 MHz board clock; all logic on its rising edge.
REQ-006 resetn  input  1  board reset, asynchronous, active-low.
REQ-007 locked  input  1  clock-wizard lock status, asynchronous to clk_in1.
REQ-008 sw_rst_req  input  1  synchronous single-cycle request to restart sequencing.
REQ-009 wiz_resetn  output  1  active-low reset driven to the clock wizard.
REQ-010 sys_rst_n  output  1  active-low reset to downstream logic, high only when sequencing is complete.
REQ-011 seq_busy  output  1  high while sequencing is in progress.
REQ-012 lock_fail  output  1  sticky flag: retries exhausted without lock.
REQ-013 retry_cnt  output  4  number of re-attempts taken since the last reset or sw_rst_req.

Function
REQ-014 locked shall pass through a 2-flop synchronizer (flops reset to 0) giving locked_s; all decisions use locked_s only.
REQ-015 FSM states: HOLD, WAIT_LOCK, STABLE, RUN, FAIL; one 16-bit cycle counter, cleared on every state change.
REQ-016 All outputs shall be registered or decoded directly from the state register: wiz_resetn=0 in HOLD and FAIL, else 1; sys_rst_n=1 only in RUN; seq_busy=1 in HOLD, WAIT_LOCK, STABLE; lock_fail=1 only in FAIL.
REQ-017 HOLD: occupies exactly HOLD_CYCLES cycles, then -> WAIT_LOCK.
REQ-018 WAIT_LOCK: locked_s=1 -> STABLE next edge; else if counter = LOCK_TIMEOUT-1 -> timeout.
REQ-019 Timeout: if retry_cnt < MAX_RETRIES then retry_cnt += 1 and -> HOLD; else -> FAIL, retry_cnt unchanged.
REQ-020 STABLE: locked_s=0 -> WAIT_LOCK with counter cleared (full timeout restarts, no retry consumed); locked_s=1 at counter = STABLE_CYCLES-1 -> RUN; STABLE therefore lasts STABLE_CYCLES cycles minimum.
REQ-021 RUN: locked_s=0 -> HOLD, retry_cnt saturating increment at 15 (lock loss in RUN does not lead to FAIL); sys_rst_n falls on the same edge the state leaves RUN.
REQ-022 FAIL: terminal; wizard held in reset; exit only via resetn or sw_rst_req.
REQ-023 sw_rst_req=1 in any state shall have priority over all other transitions: next state HOLD, counter cleared, retry_cnt=0.
REQ-024 Simultaneous timeout and locked_s rising in WAIT_LOCK: locked_s wins (-> STABLE).
REQ-025 Latency with locked constantly high: sys_rst_n rises on edge HOLD_CYCLES+1+STABLE_CYCLES after resetn deassertion (81 at defaults).
REQ-026 Worst-case lock-loss response in RUN: sys_rst_n low no later than 3 clk_in1 edges after locked falls.

Reset
REQ-027 resetn low shall asynchronously force: state HOLD, counter 0, synchronizer 0, wiz_resetn=0, sys_rst_n=0, seq_busy=1, lock_fail=0, retry_cnt=0.
REQ-028 resetn deassertion is synchronized externally; sequencing starts on the first clk_in1 edge after release.
REQ-029 resetn asserted mid-sequence (any state) shall abort immediately with REQ-027 values; no partial state survives.

Verification (HOLD_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 locked tied 1 -> wiz_resetn low for 4 cycles, sys_rst_n rises on edge 13, seq_busy falls on edge 13, retry_cnt=0.
REQ-031 locked tied 0 -> attempts at retry_cnt 0,1,2 of 36 cycles each; lock_fail=1 and wiz_resetn=0 from edge 108; sys_rst_n never rises.
REQ-032 locked low for 1 cycle during STABLE cycle 5 -> return to WAIT_LOCK, sys_rst_n stays 0, release occurs 8+ cycles after locked_s returns high, retry_cnt=0.
REQ-033 locked falls in RUN -> sys_rst_n=0 within 3 edges, retry_cnt=1, full HOLD/WAIT/STABLE re-sequence, sys_rst_n returns high.
REQ-034 sw_rst_req pulse in FAIL -> lock_fail=0, retry_cnt=0, wiz_resetn=0 for 4 cycles, normal sequencing resumes.
REQ-035 resetn pulsed low mid-STABLE -> all outputs take REQ-027 values without a clock edge; sequencing restarts from HOLD.
